cam_param: RTL and testbench

CAM_PARAM -- requirements
Module: cam_param

---
 rtl/cam_param.sv | 159 +++++++++++++++
 tb/tb_cam_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cam_param.sv
// ---------------------------------------------------------------------------
// cam_param -- parameterised content-addressable memory
//
// Holds DEPTH words of DATA_W bits, each with a valid bit. One command per
// cycle, with priority clr > ren > wen > inv:
//   clr : invalidate every entry (data words are kept)
//   ren : search for din among the valid entries; results appear one cycle
//         later on dout / hit / multi_hit / hit_cnt
//   wen : write din to entry addr and mark it valid
//   inv : invalidate entry addr
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   clr        in   invalidate all entries
//   ren        in   search request
//   wen        in   write request
//   inv        in   invalidate request
//   din        in   [DATA_W-1:0] write data / search key
//   addr       in   [ADDR_W-1:0] write / invalidate index
//   dout       out  [ADDR_W-1:0] highest matching index (registered)
//   hit        out  at least one match (registered)
//   multi_hit  out  two or more matches (registered)
//   hit_cnt    out  [ADDR_W:0] number of matches (registered)
//   used       out  [ADDR_W:0] number of valid entries
//   full       out  used == DEPTH
// ---------------------------------------------------------------------------
module cam_param #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ren,
  input  logic              wen,
  input  logic              inv,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] dout,
  output logic              hit,
  output logic              multi_hit,
  output logic [ADDR_W:0]   hit_cnt,
  output logic [ADDR_W:0]   used,
  output logic              full
);

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Occupancy counter steps that can never wrap past 0 or DEPTH.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == FULL_CNT) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  // Storage: data words carry no reset, valid bits do.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  // Command decode: only the highest-priority asserted command executes.
  logic do_clr, do_ren, do_wen, do_inv;
  logic wr_new, inv_old;

  assign do_clr  = clr;
  assign do_ren  = ren & ~clr;
  assign do_wen  = wen & ~clr & ~ren;
  assign do_inv  = inv & ~clr & ~ren & ~wen;
  // Only writes into empty slots and invalidations of live slots move used.
  assign wr_new  = do_wen & ~valid[addr];
  assign inv_old = do_inv &  valid[addr];

  // ---- stage p0: combinational compare against pre-edge storage ----
  logic [DEPTH-1:0]  match_p0;
  logic [ADDR_W-1:0] idx_p0;
  logic [CNT_W-1:0]  cnt_p0;

  always_comb begin
    match_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Invalid entries are masked so uninitialised data can never match.
      match_p0[i] = valid[i] && (mem[i] == din);
    end
  end

  always_comb begin
    idx_p0 = '0;
    cnt_p0 = '0;
    // Ascending scan: the last match seen is the highest index.
    for (int i = 0; i < DEPTH; i++) begin
      if (match_p0[i]) begin
        idx_p0 = ADDR_W'(i);
        cnt_p0 = cnt_p0 + CNT_W'(1);
      end
    end
  end

  // ---- stage p1: registered search results and storage update ----
  logic [ADDR_W-1:0] dout_p1;
  logic              hit_p1;
  logic              multi_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [CNT_W-1:0]  used_p1;

  always_ff @(posedge clk) begin
    // Writes are suppressed during reset so commands under rst have no effect.
    if (do_wen && !rst) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      used_p1  <= '0;
      dout_p1  <= '0;
      hit_p1   <= 1'b0;
      multi_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      // Results register zero on every cycle that does not execute a search.
      dout_p1  <= '0;
      hit_p1   <= 1'b0;
      multi_p1 <= 1'b0;
      cnt_p1   <= '0;
      if (do_clr) begin
        valid   <= '0;
        used_p1 <= '0;
      end else if (do_ren) begin
        dout_p1  <= idx_p0;
        hit_p1   <= |match_p0;
        multi_p1 <= (cnt_p0 >= CNT_W'(2));
        cnt_p1   <= cnt_p0;
      end else if (do_wen) begin
        valid[addr] <= 1'b1;
        if (wr_new) begin
          used_p1 <= sat_inc(used_p1);
        end
      end else if (do_inv) begin
        valid[addr] <= 1'b0;
        if (inv_old) begin
          used_p1 <= sat_dec(used_p1);
        end
      end
    end
  end

  assign dout      = dout_p1;
  assign hit       = hit_p1;
  assign multi_hit = multi_p1;
  assign hit_cnt   = cnt_p1;
  assign used      = used_p1;
  assign full      = (used_p1 == FULL_CNT);

endmodule

// File: tb/tb_cam_param.sv
// ---------------------------------------------------------------------------
// tb_cam_param -- self-checking bench for cam_param (DATA_W=8, DEPTH=16).
// Directed vector table, hand sequences for fill/overwrite and asynchronous
// reset, then randomized commands compared against an array-based model.
// ---------------------------------------------------------------------------
module tb_cam_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr, ren, wen, inv;
  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic [AW-1:0] dout;
  logic          hit, multi_hit;
  logic [AW:0]   hit_cnt, used;
  logic          full;

  cam_param #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ren(ren), .wen(wen), .inv(inv),
    .din(din), .addr(addr), .dout(dout), .hit(hit), .multi_hit(multi_hit),
    .hit_cnt(hit_cnt), .used(used), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays, expected results computed by rule.
  logic [DW-1:0] m_mem [DP];
  bit            m_valid [DP];
  bit            e_hit, e_multi;
  int            e_dout, e_cnt, e_used;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_valid();
    int n = 0;
    for (int k = 0; k < DP; k++) if (m_valid[k]) n++;
    return n;
  endfunction

  // Apply one command for one cycle, advance the model, check everything.
  task automatic step(input bit c, input bit r, input bit w, input bit i,
                      input logic [DW-1:0] d, input logic [AW-1:0] a);
    e_hit = 0; e_multi = 0; e_dout = 0; e_cnt = 0;
    if (c) begin
      for (int k = 0; k < DP; k++) m_valid[k] = 0;
    end else if (r) begin
      for (int k = DP - 1; k >= 0; k--) begin
        if (m_valid[k] && m_mem[k] == d) begin
          if (e_cnt == 0) e_dout = k;
          e_cnt++;
        end
      end
      e_hit   = (e_cnt > 0);
      e_multi = (e_cnt > 1);
    end else if (w) begin
      m_mem[a]   = d;
      m_valid[a] = 1;
    end else if (i) begin
      m_valid[a] = 0;
    end
    e_used = count_valid();
    clr = c; ren = r; wen = w; inv = i; din = d; addr = a;
    @(posedge clk);
    #1;
    chk("hit", int'(hit), int'(e_hit));
    chk("dout", int'(dout), e_dout);
    chk("multi_hit", int'(multi_hit), int'(e_multi));
    chk("hit_cnt", int'(hit_cnt), e_cnt);
    chk("used", int'(used), e_used);
    chk("full", int'(full), int'(e_used == DP));
    clr = 0; ren = 0; wen = 0; inv = 0;
  endtask

  typedef struct packed {
    logic          c, r, w, i;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          hit;
    logic [AW-1:0] dout;
    logic          multi;
    logic [AW:0]   cnt;
    logic [AW:0]   used;
  } vec_t;

  vec_t tbl [16];

  initial begin
    rst = 1'b1; clr = 0; ren = 0; wen = 0; inv = 0; din = '0; addr = '0;
    for (int k = 0; k < DP; k++) begin m_valid[k] = 0; m_mem[k] = '0; end

    //             c     r     w     i     din    addr   hit dout  mul cnt    used
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 4'd3, 1'b0, 4'd0, 1'b0, 5'd0, 5'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 4'd9, 1'b0, 4'd0, 1'b0, 5'd0, 5'd2};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b1, 4'd9, 1'b1, 5'd2, 5'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd9, 1'b0, 4'd0, 1'b0, 5'd0, 5'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b1, 4'd3, 1'b0, 5'd1, 5'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd9, 1'b0, 4'd0, 1'b0, 5'd0, 5'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 4'd9, 1'b1, 4'd3, 1'b0, 5'd1, 5'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 4'd5, 1'b0, 4'd0, 1'b0, 5'd0, 5'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 4'd5, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b1, 4'd0, 1'b0, 5'd1, 5'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0};

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_hit", int'(hit), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_cnt", int'(hit_cnt), 0);
    chk("rst_used", int'(used), 0);
    chk("rst_full", int'(full), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed table; the model runs alongside and is checked too.
    for (int v = 0; v < 16; v++) begin
      step(tbl[v].c, tbl[v].r, tbl[v].w, tbl[v].i, tbl[v].d, tbl[v].a);
      chk($sformatf("vec%0d_hit", v), int'(hit), int'(tbl[v].hit));
      chk($sformatf("vec%0d_dout", v), int'(dout), int'(tbl[v].dout));
      chk($sformatf("vec%0d_multi", v), int'(multi_hit), int'(tbl[v].multi));
      chk($sformatf("vec%0d_cnt", v), int'(hit_cnt), int'(tbl[v].cnt));
      chk($sformatf("vec%0d_used", v), int'(used), int'(tbl[v].used));
    end

    // Fill every entry, then overwrite one.
    for (int k = 0; k < DP; k++) step(0, 0, 1, 0, 8'h10 + 8'(k), 4'(k));
    chk("fill_full", int'(full), 1);
    chk("fill_used", int'(used), 16);
    step(0, 0, 1, 0, 8'hEE, 4'd4);
    chk("rewrite_used", int'(used), 16);
    step(0, 1, 0, 0, 8'h14, 4'd0);
    chk("old_value_hit", int'(hit), 0);
    step(0, 1, 0, 0, 8'hEE, 4'd0);
    chk("new_value_hit", int'(hit), 1);
    chk("new_value_dout", int'(dout), 4);

    // Asynchronous reset between edges while a hit is showing.
    #2;
    rst = 1'b1;
    #1;
    chk("async_hit", int'(hit), 0);
    chk("async_dout", int'(dout), 0);
    chk("async_used", int'(used), 0);
    chk("async_full", int'(full), 0);
    // Commands under reset are ignored; a search sampled in reset yields nothing.
    wen = 1; din = 8'h33; addr = 4'd2;
    @(posedge clk); #1;
    wen = 0; ren = 1; din = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; ren = 0;
    @(posedge clk); #1;
    chk("post_rst_hit", int'(hit), 0);
    chk("post_rst_used", int'(used), 0);
    for (int k = 0; k < DP; k++) m_valid[k] = 0;
    step(0, 1, 0, 0, 8'hEE, 4'd0);
    step(0, 1, 0, 0, 8'h33, 4'd0);

    // Randomized commands; small key space forces multi-hits and a full CAM.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 3)), 4'($urandom_range(0, DP - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
